// File: rtl/de_hazard_scoreboard.sv
// Per-register pending-write scoreboard producing the decode-stage stall.
// Each architectural register has a small counter of issued-but-unretired
// writers; source reads against a nonzero counter stall DE unless the write
// retires in the same cycle.
module de_hazard_scoreboard #(
  parameter int unsigned REGNOBITS = 5,
  parameter int unsigned REGWORDS  = 32,
  parameter int unsigned CNTBITS   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  input  logic                 issue_wr_reg,
  input  logic [REGNOBITS-1:0] issue_rd,
  input  logic                 rs1_read,
  input  logic [REGNOBITS-1:0] rs1,
  input  logic                 rs2_read,
  input  logic [REGNOBITS-1:0] rs2,
  input  logic                 retire_valid,
  input  logic [REGNOBITS-1:0] retire_rd,
  input  logic                 flush_all,
  output logic                 stall_DE,
  output logic                 issue_accept,
  output logic [REGWORDS-1:0]  busy_vec,
  output logic [3:0]           inflight_cnt,
  output logic                 err_underflow,
  output logic                 err_overflow
);

  localparam logic [CNTBITS-1:0] CNT_MAX = '1;
  localparam logic [CNTBITS-1:0] CNT_ONE = CNTBITS'(1);

  logic [CNTBITS-1:0] cnt     [REGWORDS];
  logic [CNTBITS-1:0] cnt_nxt [REGWORDS];
  logic [3:0]         inflight_q;
  logic [3:0]         inflight_nxt;
  logic               err_underflow_q;
  logic               err_overflow_q;
  logic               underflow_set;
  logic               overflow_set;

  logic               rs1_busy;
  logic               rs2_busy;
  logic               rd_full;
  logic               inc_any;
  logic               dec_any;
  logic               dec_eff;
  logic [REGWORDS-1:0] inc_vec;
  logic [REGWORDS-1:0] dec_vec;

  // Effective busy of the sources: a retire of the last pending writer
  // releases the hazard this same cycle (register file writes on the falling edge).
  always_comb begin
    rs1_busy = (cnt[rs1] != '0) &&
               !(retire_valid && (retire_rd == rs1) && (cnt[rs1] == CNT_ONE));
    rs2_busy = (cnt[rs2] != '0) &&
               !(retire_valid && (retire_rd == rs2) && (cnt[rs2] == CNT_ONE));
    rd_full  = (cnt[issue_rd] == CNT_MAX) &&
               !(retire_valid && (retire_rd == issue_rd));
    stall_DE = issue_valid &&
               ((rs1_read && (rs1 != '0) && rs1_busy) ||
                (rs2_read && (rs2 != '0) && rs2_busy) ||
                (issue_wr_reg && (issue_rd != '0) && rd_full));
    issue_accept = issue_valid && !stall_DE;
  end

  // Decoded increment/decrement requests; register 0 is never tracked.
  always_comb begin
    inc_any = issue_accept && issue_wr_reg && (issue_rd != '0);
    dec_any = retire_valid && (retire_rd != '0);
    inc_vec = REGWORDS'(inc_any) << issue_rd;
    dec_vec = REGWORDS'(dec_any) << retire_rd;
    // An underflowing retire (zero count, no same-register issue) is not a real release.
    dec_eff = dec_any &&
              !((cnt[retire_rd] == '0) && !(inc_any && (issue_rd == retire_rd)));
  end

  // Next-state of every counter plus error detection.
  always_comb begin
    cnt_nxt       = cnt;
    underflow_set = 1'b0;
    overflow_set  = 1'b0;
    for (int i = 1; i < int'(REGWORDS); i++) begin
      if (inc_vec[i] && !dec_vec[i]) begin
        if (cnt[i] == CNT_MAX) overflow_set = 1'b1;
        else                   cnt_nxt[i] = cnt[i] + CNT_ONE;
      end else if (dec_vec[i] && !inc_vec[i]) begin
        if (cnt[i] == '0) underflow_set = 1'b1;
        else              cnt_nxt[i] = cnt[i] - CNT_ONE;
      end
    end
    cnt_nxt[0] = '0;
  end

  // Net in-flight write count.
  always_comb begin
    inflight_nxt = inflight_q;
    if (inc_any && !dec_eff)      inflight_nxt = inflight_q + 4'd1;
    else if (dec_eff && !inc_any) inflight_nxt = inflight_q - 4'd1;
  end

  // State register; flush clears tracking but keeps the sticky errors.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt             <= '{default: '0};
      inflight_q      <= '0;
      err_underflow_q <= 1'b0;
      err_overflow_q  <= 1'b0;
    end else if (flush_all) begin
      cnt        <= '{default: '0};
      inflight_q <= '0;
    end else begin
      cnt             <= cnt_nxt;
      inflight_q      <= inflight_nxt;
      err_underflow_q <= err_underflow_q | underflow_set;
      err_overflow_q  <= err_overflow_q | overflow_set;
    end
  end

  // Registered view of per-register busy state.
  always_comb begin
    for (int i = 0; i < int'(REGWORDS); i++) begin
      busy_vec[i] = (cnt[i] != '0);
    end
  end

  assign inflight_cnt  = inflight_q;
  assign err_underflow = err_underflow_q;
  assign err_overflow  = err_overflow_q;

endmodule
